// File: rtl/vinstru_capture_pkg.sv
// ============================================================================
// vinstru_capture_pkg : shared types and constants for the capture stage
// Rev 1.0
// ============================================================================
`default_nettype none

package vinstru_capture_pkg;

   localparam int SAMPLE_W = 16;

   localparam logic [1:0] TRIG_IMM  = 2'd0;
   localparam logic [1:0] TRIG_RISE = 2'd1;
   localparam logic [1:0] TRIG_FALL = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_e;

   // Widened by one bit so the clamp limit itself always fits.
   function automatic logic [SAMPLE_W:0] clamp_samples(input logic [SAMPLE_W-1:0] n,
                                                       input int unsigned max_n);
      if (32'(n) > max_n) begin
         return (SAMPLE_W+1)'(max_n);
      end
      return {1'b0, n};
   endfunction

endpackage

`default_nettype wire

// File: rtl/vinstru_capture_trig.sv
// ============================================================================
// vinstru_capture_trig : previous-sample tracking and signed threshold trigger
// Rev 1.0
// ============================================================================
`default_nettype none

module vinstru_capture_trig
   import vinstru_capture_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                clr,
   input  logic                valid,
   input  logic [SAMPLE_W-1:0] data,
   input  logic [1:0]          mode,
   input  logic [SAMPLE_W-1:0] level,
   output logic                trig
);

   logic signed [SAMPLE_W-1:0] prev_q;
   logic                       prev_valid_q;
   logic signed [SAMPLE_W-1:0] w_data_s;
   logic signed [SAMPLE_W-1:0] w_level_s;
   logic                       w_rise;
   logic                       w_fall;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
      end else if (clr) begin
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
      end else if (valid) begin
         prev_q       <= $signed(data);
         prev_valid_q <= 1'b1;
      end
   end

   assign w_data_s  = $signed(data);
   assign w_level_s = $signed(level);

   // A crossing needs a prior sample, so the first one after arming never fires.
   assign w_rise = prev_valid_q && (prev_q < w_level_s) && (w_data_s >= w_level_s);
   assign w_fall = prev_valid_q && (prev_q > w_level_s) && (w_data_s <= w_level_s);

   always_comb begin
      trig = 1'b0;
      if (valid) begin
         case (mode)
            TRIG_RISE: trig = w_rise;
            TRIG_FALL: trig = w_fall;
            default:   trig = 1'b1;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/vinstru_capture.sv
// ============================================================================
// vinstru_capture : triggered 16-bit sample capture, two samples per BRAM word
// Optional trigger timestamp: define VINSTRU_CAPTURE_TIMESTAMP_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module vinstru_capture
   import vinstru_capture_pkg::*;
#(
   parameter int ADDR_W      = 14,
   parameter int MAX_SAMPLES = 2 * (2 ** (ADDR_W - 2))
) (
   input  logic                axi_aclk,
   input  logic                axi_aresetn,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic                arm,
   input  logic [1:0]          trig_mode,
   input  logic [SAMPLE_W-1:0] trig_level,
   input  logic [15:0]         nsamples,
   output logic                busy,
   output logic                done,
   output logic [15:0]         sample_count,
   output logic                bram_clk,
   output logic                bram_rst,
   output logic                bram_en,
   output logic [3:0]          bram_we,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic [31:0]         bram_din,
   input  logic [31:0]         bram_dout
`ifdef VINSTRU_CAPTURE_TIMESTAMP_EN
   ,
   output logic [31:0]         trig_time
`endif
);

   localparam int CNT_W  = SAMPLE_W + 1;
   // One spare bit so the post-increment after the final word cannot alias 0.
   localparam int WIDX_W = ADDR_W - 1;

   cap_state_e            state_q;
   cap_state_e            state_d;
   logic [CNT_W-1:0]      n_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [WIDX_W-1:0]     widx_q;
   logic [SAMPLE_W-1:0]   low_q;
   logic                  last_q;
   logic                  bram_en_q;
   logic [3:0]            bram_we_q;
   logic [ADDR_W-1:0]     bram_addr_q;
   logic [31:0]           bram_din_q;

   logic                  w_trig;
   logic                  w_trig_valid;
   logic                  w_clr;
   logic                  w_fire;
   logic                  w_store;
   logic                  w_is_last;
   logic                  w_unused;

   assign w_unused = ^bram_dout;

   assign w_trig_valid = s_valid && (state_q == ST_ARMED);
   assign w_clr        = (state_q == ST_IDLE) && arm;
   assign w_fire       = (state_q == ST_ARMED) && arm && w_trig;
   assign w_store      = (w_fire && (n_q != '0)) ||
                         ((state_q == ST_CAPTURE) && arm && !last_q && s_valid);
   assign w_is_last    = (cnt_q == (n_q - CNT_W'(1)));

   vinstru_capture_trig u_trig (
      .clk    (axi_aclk),
      .resetn (axi_aresetn),
      .clr    (w_clr),
      .valid  (w_trig_valid),
      .data   (s_data),
      .mode   (trig_mode),
      .level  (trig_level),
      .trig   (w_trig)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arm) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!arm)        state_d = ST_IDLE;
            else if (w_trig) state_d = (n_q == '0) ? ST_DONE : ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // last_q marks the cycle spent issuing the final write.
            if (!arm)        state_d = ST_IDLE;
            else if (last_q) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!arm) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         state_q     <= ST_IDLE;
         n_q         <= '0;
         cnt_q       <= '0;
         widx_q      <= '0;
         low_q       <= '0;
         last_q      <= 1'b0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= 4'h0;
         bram_addr_q <= '0;
         bram_din_q  <= '0;
      end else begin
         state_q   <= state_d;
         bram_en_q <= 1'b0;
         bram_we_q <= 4'h0;
         if (w_clr) begin
            n_q    <= clamp_samples(nsamples, 32'(MAX_SAMPLES));
            cnt_q  <= '0;
            widx_q <= '0;
            low_q  <= '0;
            last_q <= 1'b0;
         end else if (w_store) begin
            if (cnt_q != n_q) cnt_q <= cnt_q + CNT_W'(1);
            if (w_is_last) last_q <= 1'b1;
            if (!cnt_q[0]) begin
               low_q <= s_data;
               if (w_is_last) begin
                  bram_en_q   <= 1'b1;
                  bram_we_q   <= 4'h3;
                  bram_addr_q <= {widx_q[ADDR_W-3:0], 2'b00};
                  bram_din_q  <= {16'h0000, s_data};
                  widx_q      <= widx_q + WIDX_W'(1);
               end
            end else begin
               bram_en_q   <= 1'b1;
               bram_we_q   <= 4'hF;
               bram_addr_q <= {widx_q[ADDR_W-3:0], 2'b00};
               bram_din_q  <= {s_data, low_q};
               widx_q      <= widx_q + WIDX_W'(1);
            end
         end
      end
   end

`ifdef VINSTRU_CAPTURE_TIMESTAMP_EN
   logic [31:0] cyc_q;
   logic [31:0] trig_time_q;

   always_ff @(posedge axi_aclk) begin
      if (!axi_aresetn) begin
         cyc_q       <= '0;
         trig_time_q <= '0;
      end else begin
         cyc_q <= cyc_q + 32'd1;
         if (w_fire) trig_time_q <= cyc_q;
      end
   end

   assign trig_time = trig_time_q;
`endif

   assign busy         = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign done         = (state_q == ST_DONE);
   assign sample_count = cnt_q[15:0];
   assign bram_clk     = axi_aclk;
   assign bram_rst     = ~axi_aresetn;
   assign bram_en      = bram_en_q;
   assign bram_we      = bram_we_q;
   assign bram_addr    = bram_addr_q;
   assign bram_din     = bram_din_q;

endmodule

`default_nettype wire

// File: tb/tb_vinstru_capture.sv
// ============================================================================
// tb_vinstru_capture : directed self-checking bench for vinstru_capture
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vinstru_capture;

   logic        axi_aclk = 1'b0;
   logic        axi_aresetn;
   logic        s_valid;
   logic [15:0] s_data;
   logic        arm;
   logic [1:0]  trig_mode;
   logic [15:0] trig_level;
   logic [15:0] nsamples;
   logic        busy;
   logic        done;
   logic [15:0] sample_count;
   logic        bram_clk;
   logic        bram_rst;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [13:0] bram_addr;
   logic [31:0] bram_din;
   logic [31:0] bram_dout;
`ifdef VINSTRU_CAPTURE_TIMESTAMP_EN
   logic [31:0] trig_time;
   logic [31:0] tb_cyc;
   logic [31:0] exp_ts;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [13:0] addr;
      logic [3:0]  we;
      logic [31:0] din;
   } wr_t;

   wr_t wr_q[$];

   always #5 axi_aclk = ~axi_aclk;

   vinstru_capture dut (
      .axi_aclk     (axi_aclk),
      .axi_aresetn  (axi_aresetn),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .arm          (arm),
      .trig_mode    (trig_mode),
      .trig_level   (trig_level),
      .nsamples     (nsamples),
      .busy         (busy),
      .done         (done),
      .sample_count (sample_count),
      .bram_clk     (bram_clk),
      .bram_rst     (bram_rst),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .bram_dout    (bram_dout)
`ifdef VINSTRU_CAPTURE_TIMESTAMP_EN
      ,
      .trig_time    (trig_time)
`endif
   );

   always @(negedge axi_aclk) begin
      if (bram_en === 1'b1) wr_q.push_back('{addr: bram_addr, we: bram_we, din: bram_din});
   end

`ifdef VINSTRU_CAPTURE_TIMESTAMP_EN
   always @(posedge axi_aclk) begin
      if (!axi_aresetn) tb_cyc <= 32'd0;
      else              tb_cyc <= tb_cyc + 32'd1;
   end
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input int idx, input logic [13:0] addr,
                         input logic [3:0] we, input logic [31:0] din);
      if (idx < wr_q.size()) begin
         chk({tag, ".addr"}, 32'(wr_q[idx].addr), 32'(addr));
         chk({tag, ".we"},   32'(wr_q[idx].we),   32'(we));
         chk({tag, ".din"},  wr_q[idx].din,       din);
      end else begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: write %0d missing, only %0d writes seen", tag, idx, wr_q.size());
      end
   endtask

   task automatic step();
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic send(input logic [15:0] v);
      s_valid = 1'b1;
      s_data  = v;
      step();
      s_valid = 1'b0;
   endtask

   initial begin
      axi_aresetn = 1'b0;
      arm         = 1'b0;
      s_valid     = 1'b0;
      s_data      = 16'h0;
      trig_mode   = 2'd0;
      trig_level  = 16'h0;
      nsamples    = 16'h0;
      bram_dout   = 32'hDEADBEEF;
      repeat (3) step();

      chk("rst.busy",  32'(busy), 32'd0);
      chk("rst.done",  32'(done), 32'd0);
      chk("rst.en",    32'(bram_en), 32'd0);
      chk("rst.we",    32'(bram_we), 32'd0);
      chk("rst.addr",  32'(bram_addr), 32'd0);
      chk("rst.din",   bram_din, 32'd0);
      chk("rst.count", 32'(sample_count), 32'd0);
      chk("rst.bram_rst", 32'(bram_rst), 32'd1);
      axi_aresetn = 1'b1;
      step();
      chk("run.bram_rst", 32'(bram_rst), 32'd0);

      // Immediate mode, four samples
      wr_q.delete();
      trig_mode = 2'd0;
      nsamples  = 16'd4;
      arm       = 1'b1;
      step();
      chk("imm.busy_armed", 32'(busy), 32'd1);
      chk("imm.count0", 32'(sample_count), 32'd0);
      send(16'd1);
      send(16'd2);
      chk("imm.w0.en",   32'(bram_en), 32'd1);
      chk("imm.w0.addr", 32'(bram_addr), 32'h000);
      chk("imm.w0.din",  bram_din, 32'h00020001);
      send(16'd3);
      chk("imm.pulse_end", 32'(bram_en), 32'd0);
      send(16'd4);
      chk("imm.w1.en",   32'(bram_en), 32'd1);
      chk("imm.w1.we",   32'(bram_we), 32'hF);
      chk("imm.w1.addr", 32'(bram_addr), 32'h004);
      chk("imm.w1.din",  bram_din, 32'h00040003);
      chk("imm.done_early", 32'(done), 32'd0);
      step();
      chk("imm.done",  32'(done), 32'd1);
      chk("imm.busy",  32'(busy), 32'd0);
      chk("imm.count", 32'(sample_count), 32'd4);
      chk("imm.nwr",   32'(wr_q.size()), 32'd2);
      chk_wr("imm.wr0", 0, 14'h000, 4'hF, 32'h00020001);
      chk_wr("imm.wr1", 1, 14'h004, 4'hF, 32'h00040003);
      arm = 1'b0;
      step();
      chk("imm.idle_done",  32'(done), 32'd0);
      chk("imm.idle_count", 32'(sample_count), 32'd4);

      // Rising threshold at 100
      wr_q.delete();
      trig_mode  = 2'd1;
      trig_level = 16'd100;
      nsamples   = 16'd4;
      arm        = 1'b1;
      step();
      send(16'd50);
      send(16'd90);
      chk("rise.pre_count", 32'(sample_count), 32'd0);
      chk("rise.pre_busy",  32'(busy), 32'd1);
      send(16'd100);
      chk("rise.trig_count", 32'(sample_count), 32'd1);
      send(16'd120);
      send(16'd130);
      send(16'd140);
      step();
      chk("rise.done",  32'(done), 32'd1);
      chk("rise.count", 32'(sample_count), 32'd4);
      chk("rise.nwr",   32'(wr_q.size()), 32'd2);
      chk_wr("rise.wr0", 0, 14'h000, 4'hF, 32'h00780064);
      chk_wr("rise.wr1", 1, 14'h004, 4'hF, 32'h008C0082);
      arm = 1'b0;
      step();

      // Falling threshold at -10, odd length
      wr_q.delete();
      trig_mode  = 2'd2;
      trig_level = 16'hFFF6;
      nsamples   = 16'd3;
      arm        = 1'b1;
      step();
      send(16'hFFEC);
      chk("fall.first_no_trig", 32'(sample_count), 32'd0);
      send(16'h0000);
      chk("fall.zero_no_trig", 32'(sample_count), 32'd0);
      send(16'hFFF6);
      chk("fall.trig_count", 32'(sample_count), 32'd1);
      send(16'd5);
      send(16'd7);
      chk("fall.part.en",   32'(bram_en), 32'd1);
      chk("fall.part.we",   32'(bram_we), 32'h3);
      chk("fall.part.addr", 32'(bram_addr), 32'h004);
      chk("fall.part.din",  bram_din, 32'h00000007);
      chk("fall.done_early", 32'(done), 32'd0);
      step();
      chk("fall.done",  32'(done), 32'd1);
      chk("fall.count", 32'(sample_count), 32'd3);
      chk("fall.nwr",   32'(wr_q.size()), 32'd2);
      chk_wr("fall.wr0", 0, 14'h000, 4'hF, 32'h0005FFF6);
      arm = 1'b0;
      step();

      // Oversized request clamps to the BRAM capacity
      wr_q.delete();
      trig_mode = 2'd0;
      nsamples  = 16'hFFFF;
      arm       = 1'b1;
      step();
      for (int i = 0; i < 8192; i++) send(16'(i));
      chk("clamp.last.en",   32'(bram_en), 32'd1);
      chk("clamp.last.addr", 32'(bram_addr), 32'h3FFC);
      chk("clamp.last.din",  bram_din, 32'h1FFF1FFE);
      step();
      chk("clamp.done",  32'(done), 32'd1);
      chk("clamp.count", 32'(sample_count), 32'h2000);
      send(16'h1234);
      send(16'h5678);
      step();
      chk("clamp.hold_count", 32'(sample_count), 32'h2000);
      chk("clamp.hold_done",  32'(done), 32'd1);
      chk("clamp.nwr",        32'(wr_q.size()), 32'd4096);
      chk_wr("clamp.first", 0, 14'h0000, 4'hF, 32'h00010000);
      chk_wr("clamp.last", 4095, 14'h3FFC, 4'hF, 32'h1FFF1FFE);
      arm = 1'b0;
      step();

      // Abort mid-capture after five samples (mode 3 behaves as immediate)
      wr_q.delete();
      trig_mode = 2'd3;
      nsamples  = 16'd10;
      arm       = 1'b1;
      step();
`ifdef VINSTRU_CAPTURE_TIMESTAMP_EN
      exp_ts = tb_cyc;
`endif
      for (int i = 11; i <= 15; i++) send(16'(i));
      arm = 1'b0;
      step();
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      repeat (3) step();
      chk("abort.done_later", 32'(done), 32'd0);
      chk("abort.count", 32'(sample_count), 32'd5);
      chk("abort.nwr",   32'(wr_q.size()), 32'd2);
      chk_wr("abort.wr0", 0, 14'h000, 4'hF, 32'h000C000B);
      chk_wr("abort.wr1", 1, 14'h004, 4'hF, 32'h000E000D);
`ifdef VINSTRU_CAPTURE_TIMESTAMP_EN
      chk("abort.trig_time", trig_time, exp_ts);
`endif

      // Reset in the middle of a capture
      trig_mode = 2'd0;
      nsamples  = 16'd4;
      arm       = 1'b1;
      step();
      send(16'hAAAA);
      send(16'hBBBB);
      axi_aresetn = 1'b0;
      arm         = 1'b0;
      step();
      chk("mrst.busy",  32'(busy), 32'd0);
      chk("mrst.en",    32'(bram_en), 32'd0);
      chk("mrst.count", 32'(sample_count), 32'd0);
      chk("mrst.din",   bram_din, 32'd0);
      axi_aresetn = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
